// File: rtl/add12u_err_monitor.sv
`default_nettype none
// ==== add12u_err_monitor : error statistics (count, errors, sum|err|, worst case) for W-bit adders ====
// ==== rev 1.0 ====

module add12u_err_monitor #(
    parameter int W     = 12,
    parameter int CNT_W = 32,
    parameter int SUM_W = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [W:0]       in_o,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [SUM_W-1:0] sum_abs_err,
    output logic [W:0]       max_err,
    output logic [W-1:0]     max_a,
    output logic [W-1:0]     max_b,
    output logic             sat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] n_lat, n_lat_nxt;
    logic [CNT_W-1:0] accepted, accepted_nxt;
    logic             ready_nxt;
    logic             xfer;
    logic             arm;

    logic [W:0]       exact;
    logic [W:0]       err_in;
    logic             v1, v2;
    logic [W:0]       s1_err, s2_err;
    logic [W-1:0]     s1_a, s1_b, s2_a, s2_b;
    logic [SUM_W:0]   sum_ext;

    assign xfer   = in_valid & in_ready;
    assign arm    = start & ((state == IDLE) || (state == DONE));
    assign busy   = (state == RUN) || (state == DRAIN);
    assign done   = (state == DONE);

    assign exact  = {1'b0, in_a} + {1'b0, in_b};
    assign err_in = (exact >= in_o) ? (exact - in_o) : (in_o - exact);

    // Extra top bit catches the carry that signals accumulator clipping.
    assign sum_ext = {1'b0, sum_abs_err} + {{(SUM_W-W){1'b0}}, s2_err};

    always_comb begin
        state_nxt    = state;
        n_lat_nxt    = n_lat;
        accepted_nxt = accepted;
        ready_nxt    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt    = RUN;
                    n_lat_nxt    = num_samples;
                    accepted_nxt = '0;
                    ready_nxt    = (num_samples != '0);
                end
            end
            RUN: begin
                if (accepted >= n_lat) begin
                    state_nxt = DRAIN;
                end else begin
                    if (xfer) begin
                        accepted_nxt = accepted + CNT_W'(1);
                    end
                    ready_nxt = (accepted_nxt < n_lat);
                end
            end
            DRAIN: begin
                if (!v1 && !v2) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            n_lat    <= '0;
            accepted <= '0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            n_lat    <= n_lat_nxt;
            accepted <= accepted_nxt;
            in_ready <= ready_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            s1_err <= '0;
            s1_a   <= '0;
            s1_b   <= '0;
            s2_err <= '0;
            s2_a   <= '0;
            s2_b   <= '0;
        end else begin
            v1 <= xfer;
            v2 <= v1;
            if (xfer) begin
                s1_err <= err_in;
                s1_a   <= in_a;
                s1_b   <= in_b;
            end
            if (v1) begin
                s2_err <= s1_err;
                s2_a   <= s1_a;
                s2_b   <= s1_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt  <= '0;
            err_cnt     <= '0;
            sum_abs_err <= '0;
            max_err     <= '0;
            max_a       <= '0;
            max_b       <= '0;
            sat         <= 1'b0;
        end else if (arm) begin
            sample_cnt  <= '0;
            err_cnt     <= '0;
            sum_abs_err <= '0;
            max_err     <= '0;
            max_a       <= '0;
            max_b       <= '0;
            sat         <= 1'b0;
        end else if (v2) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (s2_err != '0) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            if (sum_ext[SUM_W]) begin
                sum_abs_err <= '1;
                sat         <= 1'b1;
            end else begin
                sum_abs_err <= sum_ext[SUM_W-1:0];
            end
            // Strict compare keeps the first operands that hit the worst error.
            if (s2_err > max_err) begin
                max_err <= s2_err;
                max_a   <= s2_a;
                max_b   <= s2_b;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/add12u_err_monitor.md
Name: add12u_err_monitor

Overview:
- Downstream characterisation stage for the 12-bit unsigned adder family (exact and approximate variants).
- Each cycle it consumes one operand pair (A, B) plus the candidate adder's 13-bit output O, and computes the exact sum internally.
- Over an armed run of N samples it accumulates error statistics on chip: sample count, error count, sum of absolute errors and worst-case error with its operands. MAE, EP and WCE are derived from these off-block.

Parameters:
- W, 12, operand width; the adder output is W+1 bits.
- CNT_W, 32, width of the sample counter, error counter and num_samples.
- SUM_W, 48, width of the absolute-error accumulator.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; arms a run (honoured only in IDLE or DONE).
- num_samples  in  CNT_W  samples per run; sampled on the start cycle.
- in_valid  in  1  operand/result triple valid.
- in_ready  out  1  block accepts the triple this cycle.
- in_a  in  W  adder operand A.
- in_b  in  W  adder operand B.
- in_o  in  W+1  adder output under test.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; statistics stable.
- sample_cnt  out  CNT_W  samples accumulated.
- err_cnt  out  CNT_W  samples with nonzero error.
- sum_abs_err  out  SUM_W  sum of |exact - in_o|, saturating.
- max_err  out  W+1  largest |exact - in_o|.
- max_a  out  W  operand A that produced max_err.
- max_b  out  W  operand B that produced max_err.
- sat  out  1  sticky; sum_abs_err clipped at least once this run.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0, including in_ready, busy, done and all statistics.
  - Pipeline valid bits cleared. A reset mid-run abandons the run with no residual state.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE --start--> RUN. On that edge: latch num_samples, clear every statistic, clear sat, clear the accepted counter.
  - RUN: in_ready = (accepted < N_latched). A transfer happens when in_valid & in_ready. When accepted reaches N_latched, go to DRAIN on the following edge. If N_latched = 0, go from RUN to DRAIN on the first edge with no transfer.
  - DRAIN: in_ready = 0. Go to DONE once both pipeline stages are empty (at most 2 cycles).
  - DONE: done = 1, statistics held. start re-arms the run and drops done the next cycle.
  - start is ignored in RUN and DRAIN.
- Pipeline, stage 1 (registered on transfer):
  - exact = in_a + in_b, computed W+1 bits wide with no overflow.
  - err = (exact >= in_o) ? exact - in_o : in_o - exact, W+1 bits.
  - in_a and in_b registered alongside.
- Pipeline, stage 2 (accumulate):
  - sample_cnt += 1.
  - err_cnt += 1 if err != 0.
  - sum_abs_err += err, clipped to 2^SUM_W - 1; sat is set when clipping occurs.
  - If err > max_err (strictly greater), update max_err, max_a and max_b. The first occurrence of the worst error is retained.
  - sample_cnt and err_cnt wrap is unreachable because N_latched fits CNT_W.
- Latency: a triple transferred at edge k is reflected in the statistic outputs after edge k+2.
- No bubbles are inserted: back-to-back transfers sustain 1 sample per cycle.
- in_valid without in_ready (IDLE, DRAIN, DONE, or quota reached) is dropped; no state changes.
- in_ready is a registered function of state and count only; it never depends on in_valid combinationally.

Test Plan:
- Exact-adder sweep: start with num_samples=4; feed (0,0,0), (0xFFF,0xFFF,0x1FFE), (0x800,0x800,0x1000), (1,2,3) -> done; sample_cnt=4, err_cnt=0, sum_abs_err=0, max_err=0, sat=0.
- Error capture: num_samples=3; feed (5,5,0x00B), (0x100,0x100,0x1F0), (0x100,0x100,0x210) -> err_cnt=3, sum_abs_err=1+16+16=33, max_err=16, max_a=0x100, max_b=0x100 (first occurrence kept).
- Handshake/quota: num_samples=2 with in_valid held high for 5 cycles -> exactly 2 transfers, then in_ready=0, done asserted 3 cycles after the second transfer, sample_cnt=2.
- Zero-length run: start with num_samples=0 -> in_ready stays 0, done asserted within 3 cycles, all statistics 0.
- Saturation: parameter override SUM_W=13; 3 samples each with err=0x1FFF -> sum_abs_err=0x1FFF, sat=1. A following start clears sat to 0.
- Reset mid-run: assert rst_n=0 during RUN after 2 transfers -> all outputs 0 immediately; after release, state IDLE and in_ready=0 until the next start.
